// File: rtl/mem_req_if.sv
// Data-side SRAM-like port between the memory-stage request engine and the data memory.
//   master: drives req/wr/size/addr/wstrb/wdata, receives addr_ok/data_ok/rdata
//   slave : the memory side
interface mem_req_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wstrb, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wstrb, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_req.sv
// Memory-stage data request engine. Takes one load/store micro-op from EX,
// issues a single SRAM-like transaction (byte strobes, replicated store data,
// access size), flags misaligned accesses, and hands raw read data plus the
// op's address to writeback. One transaction outstanding at a time.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_*              upstream op (valid/ready), flush from writeback
//   data_sram         SRAM-like data port (master side)
//   out_*             result to writeback (valid/ready), ALE exception flag/code
module mem_req #(
  parameter logic [5:0] ECODE_ALE = 6'h09
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_mem_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        flush,
  mem_req_if.master   data_sram,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [31:0] out_addr,
  output logic [7:0]  out_mem_op,
  output logic        out_ale,
  output logic [5:0]  out_ecode
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      state, state_nx;
  logic [7:0]  op_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        wr_q, ale_q;

  // decode of the incoming op
  logic        is_b, is_h, is_w, in_store, in_mis, in_none, accept;
  logic [1:0]  size_nx;
  logic [3:0]  wstrb_nx;
  logic [31:0] wdata_nx;
  state_t      accept_st;

  assign is_b     = in_mem_op[0] | in_mem_op[3] | in_mem_op[5];
  assign is_h     = in_mem_op[1] | in_mem_op[4] | in_mem_op[6];
  assign is_w     = in_mem_op[2] | in_mem_op[7];
  assign in_store = |in_mem_op[7:5];
  assign in_none  = (in_mem_op == 8'h00);
  assign in_mis   = (is_h & in_addr[0]) | (is_w & (|in_addr[1:0]));
  assign accept   = in_valid & in_ready;
  // non-memory and misaligned ops never touch the bus
  assign accept_st = (in_none | in_mis) ? S_DONE : S_REQ;

  assign size_nx  = is_w ? 2'd2 : (is_h ? 2'd1 : 2'd0);
  assign wdata_nx = is_w ? in_wdata :
                    is_h ? {2{in_wdata[15:0]}} :
                    is_b ? {4{in_wdata[7:0]}} : in_wdata;

  always_comb begin
    wstrb_nx = 4'b0000;
    if (in_store) begin
      if (is_w)      wstrb_nx = 4'b1111;
      else if (is_h) wstrb_nx = in_addr[1] ? 4'b1100 : 4'b0011;
      else           wstrb_nx = 4'b0001 << in_addr[1:0];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = accept_st;
      S_REQ:
        if (flush)                  state_nx = data_sram.addr_ok ? S_CANCEL : S_IDLE;
        else if (data_sram.addr_ok) state_nx = S_WAIT;
      S_WAIT:
        // a response landing with the flush is simply dropped
        if (flush)                  state_nx = data_sram.data_ok ? S_IDLE : S_CANCEL;
        else if (data_sram.data_ok) state_nx = S_DONE;
      S_DONE:
        if (flush)          state_nx = S_IDLE;
        else if (out_ready) state_nx = accept ? accept_st : S_IDLE;
      S_CANCEL: if (data_sram.data_ok) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    in_ready      = 1'b0;
    data_sram.req = 1'b0;
    out_valid     = 1'b0;
    case (state)
      S_IDLE: in_ready = !flush;
      S_REQ:  data_sram.req = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = !flush && out_ready;
      end
      default: ;
    endcase
  end

  // op / request registers; held stable for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      wstrb_q <= '0;
      wr_q    <= 1'b0;
      ale_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= in_mem_op;
      addr_q  <= in_addr;
      wdata_q <= wdata_nx;
      rdata_q <= '0;
      size_q  <= size_nx;
      wstrb_q <= wstrb_nx;
      wr_q    <= in_store;
      ale_q   <= in_mis;
    end else if (state == S_WAIT && data_sram.data_ok && !flush && !wr_q) begin
      rdata_q <= data_sram.rdata;
    end
  end

  assign data_sram.wr    = wr_q;
  assign data_sram.size  = size_q;
  assign data_sram.addr  = addr_q;
  assign data_sram.wstrb = wstrb_q;
  assign data_sram.wdata = wdata_q;

  assign out_rdata  = rdata_q;
  assign out_addr   = addr_q;
  assign out_mem_op = op_q;
  assign out_ale    = ale_q;
  assign out_ecode  = ale_q ? ECODE_ALE : 6'h00;
endmodule
